// File: rtl/ie_defs_pkg.sv
// Shared definitions for the host UART debug/load protocol: command bytes and
// the command decoder state encoding.
package ie_defs;

  localparam logic [7:0] CMD_WRITE   = 8'h02;
  localparam logic [7:0] CMD_READ    = 8'h03;
  localparam logic [7:0] CMD_HOLD    = 8'h06;
  localparam logic [7:0] CMD_RELEASE = 8'h07;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_BUS_WR,
    S_BUS_RD,
    S_TX_RESP,
    S_TX_WAIT
  } state_t;

endpackage

// File: rtl/uart_cmd_decoder.sv
// Host UART command responder: decodes WRITE/READ/HOLD/RELEASE, masters the
// system bus and returns read data. Optional inter-byte timeout: CMD_TIMEOUT_EN.
module uart_cmd_decoder
  import ie_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        cpu_hold,
  output logic        busy
);

  state_t state, state_next;
  logic   is_read;
  logic   timeout;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] idle_cnt;

  // Saturates at TMAX so a long idle period in IDLE cannot wrap around.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idle_cnt <= '0;
    else if (rx_valid)
      idle_cnt <= '0;
    else if (idle_cnt != TMAX)
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout = (idle_cnt == TMAX);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:
        if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ))
          state_next = S_ADDR_HI;
      S_ADDR_HI:
        if (rx_valid)     state_next = S_ADDR_LO;
        else if (timeout) state_next = S_IDLE;
      S_ADDR_LO:
        if (rx_valid)     state_next = is_read ? S_BUS_RD : S_DATA;
        else if (timeout) state_next = S_IDLE;
      S_DATA:
        if (rx_valid)     state_next = S_BUS_WR;
        else if (timeout) state_next = S_IDLE;
      S_BUS_WR:
        if (bus_ack) state_next = S_IDLE;
      S_BUS_RD:
        if (bus_ack) state_next = S_TX_RESP;
      S_TX_RESP:
        if (!tx_active) state_next = S_TX_WAIT;
      S_TX_WAIT:
        if (tx_done) state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req = (state == S_BUS_WR) || (state == S_BUS_RD);
    bus_we  = (state == S_BUS_WR);
    busy    = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_read   <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_hold  <= 1'b0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
    end else begin
      tx_start <= (state == S_TX_RESP) && !tx_active;
      case (state)
        S_IDLE:
          if (rx_valid) begin
            if (rx_data == CMD_WRITE)   is_read  <= 1'b0;
            if (rx_data == CMD_READ)    is_read  <= 1'b1;
            if (rx_data == CMD_HOLD)    cpu_hold <= 1'b1;
            if (rx_data == CMD_RELEASE) cpu_hold <= 1'b0;
          end
        S_ADDR_HI:
          if (rx_valid) bus_addr[15:8] <= rx_data;
        S_ADDR_LO:
          if (rx_valid) bus_addr[7:0] <= rx_data;
        S_DATA:
          if (rx_valid) bus_wdata <= rx_data;
        S_BUS_RD:
          if (bus_ack) tx_data <= bus_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

FPGA-side responder for the host UART debug/load protocol: consumes bytes from `uart_rx`, decodes write/read/CPU-hold commands, masters the system memory bus and returns read data through `UART_TX`. Sits inside `nes_fpga_top_lvl` between the UART pair and the system bus arbiter. Used for loading PGROM/CHR memory and for readback before the CPU is released.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 2_500_000: inter-byte timeout in `clk` cycles. Only used when `CMD_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock (25 MHz domain shared with the UARTs)
- `rst`  in  1  reset, asynchronous, active-high
- `rx_valid`  in  1  one-cycle pulse, `rx_data` valid
- `rx_data`  in  8  received byte
- `tx_start`  out  1  one-cycle pulse to `UART_TX`
- `tx_data`  out  8  byte to transmit, held stable from `tx_start` until `tx_done`
- `tx_active`  in  1  transmitter busy
- `tx_done`  in  1  one-cycle pulse at end of stop bit
- `bus_req`  out  1  bus request, held until `bus_ack`
- `bus_we`  out  1  1 = write, 0 = read; valid while `bus_req`
- `bus_addr`  out  16  bus address
- `bus_wdata`  out  8  write data
- `bus_rdata`  in  8  read data, sampled on `bus_ack`
- `bus_ack`  in  1  one-cycle completion pulse
- `cpu_hold`  out  1  1 = CPU/PPU held in reset, bus free for host
- `busy`  out  1  high whenever state is not IDLE

## Operation
- Command bytes: 0x02 WRITE (addr_hi, addr_lo, data), 0x03 READ (addr_hi, addr_lo; one byte returned), 0x06 HOLD (`cpu_hold` <= 1), 0x07 RELEASE (`cpu_hold` <= 0). Any other byte in IDLE is ignored.
- States: IDLE, ADDR_HI, ADDR_LO, DATA, BUS_WR, BUS_RD, TX_RESP, TX_WAIT.
- IDLE: on 0x02/0x03, latch `is_read`, go to ADDR_HI. On 0x06/0x07, update `cpu_hold` and stay in IDLE.
- ADDR_HI -> ADDR_LO -> (WRITE: DATA -> BUS_WR; READ: BUS_RD). Each advance occurs on `rx_valid` and latches the byte into `bus_addr[15:8]`, `bus_addr[7:0]`, or `bus_wdata`.
- BUS_WR/BUS_RD: `bus_req` = 1 until `bus_ack`. On ack, WRITE returns to IDLE. READ latches `bus_rdata` into `tx_data` and goes to TX_RESP.
- TX_RESP: if `tx_active` = 0, pulse `tx_start` and go to TX_WAIT. Otherwise wait.
- TX_WAIT: on `tx_done`, go to IDLE.
- `rx_valid` pulses in BUS_WR/BUS_RD/TX_RESP/TX_WAIT are dropped. The host is required to wait for the response.
- Bus accesses are issued regardless of `cpu_hold`. Arbitration is external.

## Timing
- Reset values: `tx_start` 0, `tx_data` 0x00, `bus_req` 0, `bus_we` 0, `bus_addr` 0x0000, `bus_wdata` 0x00, `cpu_hold` 0, `busy` 0; state IDLE.
- `rx_valid` of the final WRITE data byte at cycle N: `bus_req`/`bus_we` = 1 at N+1.
- `rx_valid` of READ addr_lo at cycle N: `bus_req` = 1, `bus_we` = 0 at N+1.
- `bus_ack` at cycle M: `bus_req` = 0 at M+1. For READ with an idle transmitter, `tx_start` pulses at M+2 for exactly one cycle.
- `bus_ack` in the same cycle `bus_req` rises is legal; minimum WRITE bus phase is 1 cycle.
- HOLD/RELEASE: `cpu_hold` changes at N+1 after the command byte's `rx_valid`.
- `tx_done` while not in TX_WAIT: ignored.
- Async `rst` mid-transaction: immediate return to IDLE with all outputs at reset values. Any partial command is discarded.

## Configuration
- `CMD_TIMEOUT_EN` defined: a counter clears on every `rx_valid`. If it reaches `TIMEOUT_CYCLES` while in ADDR_HI, ADDR_LO or DATA, the FSM returns to IDLE next cycle and discards the partial command. BUS_* and TX_* states never time out.
- Not defined: no counter; the FSM waits indefinitely for the remaining bytes.

## Structure
- Shared package `ie_defs` holds the command byte constants (`CMD_WRITE`=8'h02, `CMD_READ`=8'h03, `CMD_HOLD`=8'h06, `CMD_RELEASE`=8'h07) and the state enum typedef.
- Single module, no sub-modules. The timeout counter is inline under the macro.

## Test plan
- Bytes 02,80,00,A5 -> one `bus_req` cycle-group with `bus_we`=1, `bus_addr`=0x8000, `bus_wdata`=0xA5; ack -> IDLE, no `tx_start`.
- Bytes 03,20,07, ack with `bus_rdata`=0x3C -> `bus_we`=0, `bus_addr`=0x2007; one `tx_start` with `tx_data`=0x3C; IDLE after `tx_done`.
- Bytes 06 then 07 -> `cpu_hold` 0→1 then 1→0, each one cycle after `rx_valid`; bytes 55,FF in IDLE -> no state change.
- READ while `tx_active`=1 -> `tx_start` held off until `tx_active`=0, then a single pulse; a stray `rx_valid` in TX_WAIT is dropped.
- `rst` pulse after 02,12 -> outputs at reset values; following 03,00,10 decodes as a clean READ of 0x0010.
- With `CMD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16: bytes 02,80 then 16 idle cycles -> IDLE; next byte 07 clears `cpu_hold`.
